// File: rtl/alu_acc_seq.sv
// -----------------------------------------------------------------------------
// alu_acc_seq
// Registered accumulator ALU. The accumulator A and the carry/zero flags live
// inside this block. One operation is accepted per valid/ready handshake. The
// block offers carry-chained add/subtract, logical ops, shifts and an optional
// multi-cycle shift-add multiply.
//
// Configuration macro: ALU_ACC_MUL_EN
//   defined   : opcode 11 runs a WIDTH-step shift-add multiply (state MUL_RUN)
//   undefined : opcode 11 is treated as reserved; ready is tied high
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   valid  in   1      operation request, accepted when valid && ready && !clr
//   op     in   4      opcode, sampled at accept
//   r      in   WIDTH  second operand, sampled at accept
//   clr    in   1      synchronous clear of A/flags, aborts a running multiply
//   ready  out  1      idle, able to accept an operation this cycle
//   done   out  1      one-cycle pulse: result visible on a/cy/z
//   err    out  1      one-cycle pulse with done for a reserved/disabled opcode
//   a      out  WIDTH  accumulator
//   cy     out  1      carry/borrow flag
//   z      out  1      zero flag of the last written A
// -----------------------------------------------------------------------------
module alu_acc_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] r,
    input  logic             clr,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] a,
    output logic             cy,
    output logic             z
);

    logic [WIDTH-1:0] a_reg, a_next;
    logic             cy_reg, cy_next;
    logic             z_reg, z_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] alu_a;
    logic             alu_cy;
    logic             alu_err;
    logic [WIDTH:0]   ext_res;
    logic             accept;

`ifdef ALU_ACC_MUL_EN
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MUL_RUN = 1'b1;
    localparam int CNT_W = $clog2(WIDTH);

    logic [0:0]         state_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] prod_sum;
    logic               alu_mul;
    logic               mul_last;

    assign ready    = (state_reg == IDLE);
    assign prod_sum = prod_reg + (mplier_reg[0] ? mcand_reg : {(2*WIDTH){1'b0}});
    assign mul_last = (state_reg == MUL_RUN) && (cnt_reg == CNT_W'(WIDTH-1));
`else
    assign ready = 1'b1;
`endif

    // A request arriving together with clr is dropped, not queued.
    assign accept = valid && ready && !clr;

    // Single-cycle result of the current opcode against the current A/CY.
    always_comb begin
        alu_a   = a_reg;
        alu_cy  = cy_reg;
        alu_err = 1'b0;
        ext_res = {(WIDTH+1){1'b0}};
`ifdef ALU_ACC_MUL_EN
        alu_mul = 1'b0;
`endif
        case (op)
            4'd0: begin
                ext_res = {1'b0, a_reg} + {1'b0, r};
                {alu_cy, alu_a} = ext_res;
            end
            4'd1: begin
                // Bit WIDTH of the extended difference is the borrow.
                ext_res = {1'b0, a_reg} - {1'b0, r};
                {alu_cy, alu_a} = ext_res;
            end
            4'd2: begin alu_a = a_reg | r; alu_cy = 1'b0; end
            4'd3: begin alu_a = a_reg & r; alu_cy = 1'b0; end
            4'd4: begin alu_a = a_reg ^ r; alu_cy = 1'b0; end
            4'd5: begin alu_a = ~a_reg;    alu_cy = 1'b0; end
            4'd6: begin alu_a = r;         alu_cy = 1'b0; end
            4'd7: begin
                ext_res = {1'b0, a_reg} + {1'b0, r} + {{WIDTH{1'b0}}, cy_reg};
                {alu_cy, alu_a} = ext_res;
            end
            4'd8: begin
                ext_res = {1'b0, a_reg} - {1'b0, r} - {{WIDTH{1'b0}}, cy_reg};
                {alu_cy, alu_a} = ext_res;
            end
            4'd9: begin
                alu_cy = a_reg[WIDTH-1];
                alu_a  = {a_reg[WIDTH-2:0], 1'b0};
            end
            4'd10: begin
                alu_cy = a_reg[0];
                alu_a  = {1'b0, a_reg[WIDTH-1:1]};
            end
`ifdef ALU_ACC_MUL_EN
            4'd11: alu_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // Accumulator/flag update; clr wins over everything except reset.
    always_comb begin
        a_next    = a_reg;
        cy_next   = cy_reg;
        z_next    = z_reg;
        done_next = 1'b0;
        err_next  = 1'b0;
        if (clr) begin
            a_next  = {WIDTH{1'b0}};
            cy_next = 1'b0;
            z_next  = 1'b1;
`ifdef ALU_ACC_MUL_EN
        end else if (mul_last) begin
            a_next    = prod_sum[WIDTH-1:0];
            cy_next   = |prod_sum[2*WIDTH-1:WIDTH];
            z_next    = (prod_sum[WIDTH-1:0] == {WIDTH{1'b0}});
            done_next = 1'b1;
        end else if (accept && !alu_mul) begin
`else
        end else if (accept) begin
`endif
            a_next    = alu_a;
            cy_next   = alu_cy;
            z_next    = (alu_a == {WIDTH{1'b0}});
            done_next = 1'b1;
            err_next  = alu_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= {WIDTH{1'b0}};
            cy_reg   <= 1'b0;
            z_reg    <= 1'b1;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            a_reg    <= a_next;
            cy_reg   <= cy_next;
            z_reg    <= z_next;
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

`ifdef ALU_ACC_MUL_EN
    // Shift-add multiplier: multiplicand shifts left, multiplier shifts right,
    // one partial product added per cycle for WIDTH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= {(2*WIDTH){1'b0}};
            mplier_reg <= {WIDTH{1'b0}};
            prod_reg   <= {(2*WIDTH){1'b0}};
            cnt_reg    <= {CNT_W{1'b0}};
        end else if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= {CNT_W{1'b0}};
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && alu_mul) begin
                        state_reg  <= MUL_RUN;
                        mcand_reg  <= {{WIDTH{1'b0}}, r};
                        mplier_reg <= a_reg;
                        prod_reg   <= {(2*WIDTH){1'b0}};
                        cnt_reg    <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    prod_reg   <= prod_sum;
                    mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (mul_last) state_reg <= IDLE;
                end
            endcase
        end
    end
`endif

    assign a    = a_reg;
    assign cy   = cy_reg;
    assign z    = z_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_alu_acc_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_acc_seq
// Directed-vector bench for alu_acc_seq (WIDTH=8). Multiply vectors are built
// only when ALU_ACC_MUL_EN is defined; otherwise opcode 11 is checked as
// reserved.
// -----------------------------------------------------------------------------
module tb_alu_acc_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         clr = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] r = '0;
    logic         ready, done, err, cy, z;
    logic [W-1:0] a;

    int n_cmp = 0;
    int n_bad = 0;

    alu_acc_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .op    (op),
        .r     (r),
        .clr   (clr),
        .ready (ready),
        .done  (done),
        .err   (err),
        .a     (a),
        .cy    (cy),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request, wait for the accepting edge, check the result one
    // cycle later. Calling it again immediately keeps valid high (back-to-back).
    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] v,
                         input logic [W-1:0] ea, input logic ecy, input logic eerr);
        valid = 1'b1; op = o; r = v;
        @(posedge clk); #1;
        valid = 1'b0;
        $display("%s: op=%0d r=0x%02h -> a=0x%02h cy=%0b z=%0b done=%0b err=%0b",
                 tag, o, v, a, cy, z, done, err);
        check({tag, ".done"}, 32'(done), 32'(1'b1));
        check({tag, ".a"},    32'(a),    32'(ea));
        check({tag, ".cy"},   32'(cy),   32'(ecy));
        check({tag, ".z"},    32'(z),    32'(ea == '0));
        check({tag, ".err"},  32'(err),  32'(eerr));
    endtask

`ifdef ALU_ACC_MUL_EN
    // Run a multiply to completion while holding a junk LD request that must
    // be ignored; reports cycles to done and cycles with ready low.
    task automatic run_mul(input string tag, input logic [W-1:0] v,
                           input logic [W-1:0] ea, input logic ecy);
        int n;
        int low;
        valid = 1'b1; op = 4'd11; r = v;
        @(posedge clk); #1;
        op = 4'd6; r = 8'hAA;
        n = 1; low = 0;
        if (!ready) low++;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!ready) low++;
        end
        valid = 1'b0;
        $display("%s: MUL r=0x%02h -> a=0x%02h cy=%0b z=%0b done@%0d ready_low=%0d",
                 tag, v, a, cy, z, n, low);
        check({tag, ".lat"},   32'(n),   32'(W + 1));
        check({tag, ".busy"},  32'(low), 32'(W));
        check({tag, ".a"},     32'(a),   32'(ea));
        check({tag, ".cy"},    32'(cy),  32'(ecy));
        check({tag, ".z"},     32'(z),   32'(ea == '0));
        check({tag, ".err"},   32'(err), 32'(1'b0));
        check({tag, ".ready"}, 32'(ready), 32'(1'b1));
    endtask
`endif

    initial begin
        bit seen;

        // Power-up reset
        repeat (2) @(posedge clk);
        #1;
        $display("reset: a=0x%02h cy=%0b z=%0b ready=%0b", a, cy, z, ready);
        check("rst.a",     32'(a),     32'h0);
        check("rst.cy",    32'(cy),    32'h0);
        check("rst.z",     32'(z),     32'h1);
        check("rst.ready", 32'(ready), 32'h1);
        check("rst.done",  32'(done),  32'h0);
        check("rst.err",   32'(err),   32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry chain
        issue("ld_f0",  4'd6, 8'hF0, 8'hF0, 1'b0, 1'b0);
        issue("add_20", 4'd0, 8'h20, 8'h10, 1'b1, 1'b0);
        issue("adc_00", 4'd7, 8'h00, 8'h11, 1'b0, 1'b0);
        // Borrow chain
        issue("ld_05",  4'd6, 8'h05, 8'h05, 1'b0, 1'b0);
        issue("sub_05", 4'd1, 8'h05, 8'h00, 1'b0, 1'b0);
        issue("sbb_01", 4'd8, 8'h01, 8'hFF, 1'b1, 1'b0);
        // Shifts and NOT
        issue("ld_81",  4'd6, 8'h81, 8'h81, 1'b0, 1'b0);
        issue("shl",    4'd9, 8'h00, 8'h02, 1'b1, 1'b0);
        issue("shr",    4'd10, 8'h00, 8'h01, 1'b0, 1'b0);
        issue("not",    4'd5, 8'h00, 8'hFE, 1'b0, 1'b0);

        // Idle cycle: done/err must not persist
        @(posedge clk); #1;
        check("idle.done", 32'(done), 32'h0);
        check("idle.err",  32'(err),  32'h0);

        // Logical ops clear a set carry
        issue("shl_fe", 4'd9, 8'h00, 8'hFC, 1'b1, 1'b0);
        issue("or_03",  4'd2, 8'h03, 8'hFF, 1'b0, 1'b0);
        issue("and_0f", 4'd3, 8'h0F, 8'h0F, 1'b0, 1'b0);
        issue("xor_0f", 4'd4, 8'h0F, 8'h00, 1'b0, 1'b0);

        // Reserved opcodes keep A and CY
        issue("ld_ff",  4'd6, 8'hFF, 8'hFF, 1'b0, 1'b0);
        issue("add_3d", 4'd0, 8'h3D, 8'h3C, 1'b1, 1'b0);
        issue("rsv13",  4'd13, 8'hAA, 8'h3C, 1'b1, 1'b1);
`ifndef ALU_ACC_MUL_EN
        issue("rsv11",  4'd11, 8'h55, 8'h3C, 1'b1, 1'b1);
        check("rsv11.ready", 32'(ready), 32'h1);
`endif

        // clr together with a request: request dropped, state cleared
        valid = 1'b1; op = 4'd6; r = 8'h55; clr = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; clr = 1'b0;
        $display("clr+valid: a=0x%02h cy=%0b z=%0b done=%0b", a, cy, z, done);
        check("clrv.a",    32'(a),    32'h0);
        check("clrv.cy",   32'(cy),   32'h0);
        check("clrv.z",    32'(z),    32'h1);
        check("clrv.done", 32'(done), 32'h0);

`ifdef ALU_ACC_MUL_EN
        issue("ld_10", 4'd6, 8'h10, 8'h10, 1'b0, 1'b0);
        run_mul("mul_11", 8'h11, 8'h10, 1'b1);
        issue("ld_0c", 4'd6, 8'h0C, 8'h0C, 1'b0, 1'b0);
        run_mul("mul_0a", 8'h0A, 8'h78, 1'b0);

        // Abort a multiply with clr on its 4th busy cycle
        issue("ld_0c2", 4'd6, 8'h0C, 8'h0C, 1'b0, 1'b0);
        valid = 1'b1; op = 4'd11; r = 8'h0A;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        $display("mul abort: a=0x%02h cy=%0b z=%0b ready=%0b done=%0b", a, cy, z, ready, done);
        check("abort.a",     32'(a),     32'h0);
        check("abort.cy",    32'(cy),    32'h0);
        check("abort.z",     32'(z),     32'h1);
        check("abort.ready", 32'(ready), 32'h1);
        seen = done;
        repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        check("abort.nodone", 32'(seen), 32'h0);

        // Async reset during a multiply
        issue("ld_07", 4'd6, 8'h07, 8'h07, 1'b0, 1'b0);
        valid = 1'b1; op = 4'd11; r = 8'h03;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        $display("mul reset: a=0x%02h ready=%0b done=%0b", a, ready, done);
        check("mrst.a",     32'(a),     32'h0);
        check("mrst.ready", 32'(ready), 32'h1);
        check("mrst.done",  32'(done),  32'h0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        check("mrst.nodone", 32'(seen), 32'h0);
`endif

        // Mid-cycle async reset from a non-reset state
        issue("ld_3c", 4'd6, 8'h3C, 8'h3C, 1'b0, 1'b0);
        issue("shl_3c", 4'd9, 8'h00, 8'h78, 1'b0, 1'b0);
        issue("add_90", 4'd0, 8'h90, 8'h08, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: a=0x%02h cy=%0b z=%0b ready=%0b", a, cy, z, ready);
        check("arst.a",     32'(a),     32'h0);
        check("arst.cy",    32'(cy),    32'h0);
        check("arst.z",     32'(z),     32'h1);
        check("arst.ready", 32'(ready), 32'h1);
        check("arst.done",  32'(done),  32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
